// File: rtl/gauss_stat.sv
// Windowed mean / mean-power statistics over a valid-qualified stream of sample pairs.
// Optional cross-product term is built when GAUSS_STAT_CORR_EN is defined; otherwise corr is tied to 0.
module gauss_stat #(
  parameter int OUT   = 32,
  parameter int LOG_N = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_val,
  input  logic signed [OUT-1:0] in1,
  input  logic signed [OUT-1:0] in2,
  output logic                  busy,
  output logic                  res_val,
  output logic signed [OUT-1:0] mean1,
  output logic signed [OUT-1:0] mean2,
  output logic [2*OUT-1:0]      pow1,
  output logic [2*OUT-1:0]      pow2,
  output logic signed [2*OUT-1:0] corr
);

  localparam int AW = OUT + LOG_N;
  localparam int SW = 2*OUT + LOG_N;

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DRAIN, S_DONE} state_t;

  state_t state, state_nxt;

  logic [LOG_N:0] cnt;
  logic           drn;
  logic           accept, win_start, fin;

  logic signed [2*OUT-1:0] x1, x2, p11, p22;
  logic                    s1_val;
  logic signed [OUT-1:0]   s1_in1, s1_in2;
  logic [2*OUT-1:0]        s1_sq1, s1_sq2;
  logic signed [AW-1:0]    acc1, acc2;
  logic [SW-1:0]           sqa1, sqa2;

  assign busy      = (state != S_IDLE);
  assign accept    = (state == S_ACC) && in_val && !cnt[LOG_N];
  assign win_start = (state == S_IDLE) && start;
  assign fin       = (state == S_DRAIN) && drn;

  assign x1  = {{OUT{in1[OUT-1]}}, in1};
  assign x2  = {{OUT{in2[OUT-1]}}, in2};
  assign p11 = x1 * x1;
  assign p22 = x2 * x2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = S_ACC;
      S_ACC:   if (cnt[LOG_N]) state_nxt = S_DRAIN;
      S_DRAIN: if (drn) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      drn     <= 1'b0;
      s1_val  <= 1'b0;
      s1_in1  <= '0;
      s1_in2  <= '0;
      s1_sq1  <= '0;
      s1_sq2  <= '0;
      acc1    <= '0;
      acc2    <= '0;
      sqa1    <= '0;
      sqa2    <= '0;
      res_val <= 1'b0;
      mean1   <= '0;
      mean2   <= '0;
      pow1    <= '0;
      pow2    <= '0;
    end else begin
      drn     <= (state == S_DRAIN) && !drn;
      res_val <= fin;

      s1_val <= accept;
      if (accept) begin
        s1_in1 <= in1;
        s1_in2 <= in2;
        s1_sq1 <= p11;
        s1_sq2 <= p22;
      end

      if (win_start) begin
        cnt  <= '0;
        acc1 <= '0;
        acc2 <= '0;
        sqa1 <= '0;
        sqa2 <= '0;
      end else begin
        if (accept) cnt <= cnt + (LOG_N+1)'(1);
        if (s1_val) begin
          acc1 <= acc1 + {{LOG_N{s1_in1[OUT-1]}}, s1_in1};
          acc2 <= acc2 + {{LOG_N{s1_in2[OUT-1]}}, s1_in2};
          sqa1 <= sqa1 + {{LOG_N{1'b0}}, s1_sq1};
          sqa2 <= sqa2 + {{LOG_N{1'b0}}, s1_sq2};
        end
      end

      // Shift-then-truncate collapses to taking the top bits of each accumulator.
      if (fin) begin
        mean1 <= acc1[AW-1:LOG_N];
        mean2 <= acc2[AW-1:LOG_N];
        pow1  <= sqa1[SW-1:LOG_N];
        pow2  <= sqa2[SW-1:LOG_N];
      end
    end
  end

`ifdef GAUSS_STAT_CORR_EN
  logic signed [2*OUT-1:0] pxy, s1_xy;
  logic signed [SW-1:0]    accx;

  assign pxy = x1 * x2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_xy <= '0;
      accx  <= '0;
      corr  <= '0;
    end else begin
      if (accept) s1_xy <= pxy;
      if (win_start)   accx <= '0;
      else if (s1_val) accx <= accx + {{LOG_N{s1_xy[2*OUT-1]}}, s1_xy};
      if (fin) corr <= accx[SW-1:LOG_N];
    end
  end
`else
  assign corr = '0;
`endif

endmodule
